ac97_square_mixer: RTL and testbench
====================================

// Module: ac97_square_mixer
// PURPOSE
// - NUM_CH-voice square-wave tone generator and stereo mixer, the parametrised successor of the single-voice tone path.
// - Per voice: phase accumulator, duty select, 4-bit volume, L/R pan and retrigger.
// - Voices are summed over one shared, time-multiplexed datapath, one voice per bitclk.
// - Output is a saturated 20-bit signed sample on AC97 slot3 (L) and slot4 (R). Sits between tone control logic and ACLink.
// PARAMETERS
// - NUM_CH     4   number of voices, 1..16 (must finish well inside one 256-bit frame)
// - PHASE_W    20  phase accumulator width
// - AMP_SHIFT  12  voice amplitude = vol << AMP_SHIFT
// PORTS
// - ac97_bitclk     in   1             AC97 bit clock, sole clock
// - rst             in   1             reset, asynchronous, active-high
// - ac97_strobe     in   1             frame strobe from ACLink, 1 cycle per 256 bitclks
// - ch_enable       in   NUM_CH        voice enable
// - ch_trigger      in   NUM_CH        1-cycle pulse: restart voice phase at 0
// - ch_inc          in   NUM_CH*PHASE_W  phase increment per frame, voice i at [i*PHASE_W +: PHASE_W]
// - ch_duty         in   2*NUM_CH      duty code: 00=12.5%, 01=25%, 10=50%, 11=75%
// - ch_vol          in   4*NUM_CH      volume 0..15
// - ch_pan_l        in   NUM_CH        voice routed to left
// - ch_pan_r        in   NUM_CH        voice routed to right
// - ac97_out_slot3  out  20            left sample, signed
// - ac97_out_slot4  out  20            right sample, signed
// - busy            out  1             mixing in progress
// - overrun         out  1             sticky: strobe arrived while busy
// BEHAVIOUR
// - Reset: all phases, pending triggers, accumulators and mix_l/mix_r = 0; slot3/slot4 = 0; busy = 0; overrun = 0; FSM = IDLE.
// - FSM IDLE -> MIX on a strobe edge. MIX stays for NUM_CH cycles, idx 0..NUM_CH-1. MIX -> DONE after idx = NUM_CH-1. DONE -> IDLE next cycle.
// - Strobe edge in any state:
//   - slot3 <= mix_l and slot4 <= mix_r (last completed mix);
//   - acc_l = acc_r = 0; idx = 0; busy = 1.
// - Latency: a voice's settings reach the slots at the strobe after the one that started its mix, i.e. one frame.
// - MIX cycle for voice i = idx, inputs sampled that cycle:
//   - if !ch_enable[i]: phase[i] <= 0, contribution 0;
//   - else if trig_pend[i]: phase[i] <= 0, contribution from phase 0;
//   - else phase[i] <= phase[i] + inc[i] mod 2^PHASE_W, contribution from the new phase.
// - Wave: p3 = top 3 bits of the new phase. High when p3 < thr, thr = 1/2/4/6 for duty 00/01/10/11.
// - Contribution: +(vol<<AMP_SHIFT) when high, -(vol<<AMP_SHIFT) when low; vol = 0 gives 0.
//   - Added to acc_l if pan_l, to acc_r if pan_r; both or neither allowed.
// - Accumulators: signed, 21+clog2(NUM_CH) bits, so the sum never overflows.
// - DONE: mix_l/mix_r <= acc saturated to the 20-bit signed range [-524288, 524287]; busy <= 0.
// - ch_trigger pulse sets trig_pend[i] in any state; it is cleared when voice i is processed.
//   - Trigger and processing in the same cycle: the trigger applies to this processing, and pend stays 0.
// - Strobe while busy: overrun <= 1 (cleared only by reset).
//   - The slots take the old mix_l/mix_r. The partial mix is discarded and restarted at idx 0.
//   - Voices already processed keep their advanced phase.
// - Reset asserted mid-MIX: immediate return to the reset values above; no partial result is kept.
// STRUCTURE
// - Package ac97_audio_pkg:
//   - SLOT_W = 20, SAMPLE_MAX / SAMPLE_MIN;
//   - duty code enum and duty threshold function;
//   - FSM state enum {IDLE, MIX, DONE}.
// - Sub-module ac97_sat20: combinational signed saturation from ACC_W to 20 bits; one instance per channel.
// - Phase registers are an array indexed by idx; there is one shared adder and one compare path.
// TESTING
// - Reset mid-MIX: assert rst at idx = 2 -> slots 0, busy 0, overrun 0, all phases 0 on the next edge.
// - Single voice, NUM_CH=4, ch0 enabled, inc = 2^17, duty 10, vol 15, pan L only:
//   - p3 steps 1,2,3..7,0, and L follows it: +61440 for 3 frames, -61440 for 4 frames, then +61440 (new phase 0, p3 = 0);
//   - slot4 = 0 throughout; busy high for exactly 4 cycles after each strobe.
// - Duty 00, inc = 2^17 -> exactly 1 high frame per 8-frame period. Duty 11 -> 6 of 8.
// - Saturation, AMP_SHIFT = 14, all 4 voices high, vol 15, pan both:
//   - raw sum 983040 -> slots 524287;
//   - all low -> slots -524288.
// - Retrigger: pulse ch_trigger[1] while idle at arbitrary phase -> voice 1 phase 0 after its next MIX cycle.
//   - Disable a voice -> contribution 0 and phase 0.
// - Overrun: strobe 2 cycles after a strobe, NUM_CH = 4 -> overrun = 1; slots unchanged from the prior mix; mix restarts at idx 0.

Source files
------------

// File: rtl/ac97_audio_pkg.sv
// Shared AC97 audio types, sample limits and duty-cycle decoding.
package ac97_audio_pkg;

  localparam int SLOT_W = 20;
  localparam logic signed [SLOT_W-1:0] SAMPLE_MAX = 20'sh7FFFF;
  localparam logic signed [SLOT_W-1:0] SAMPLE_MIN = 20'sh80000;

  typedef enum logic [1:0] {
    DUTY_12 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_50 = 2'b10,
    DUTY_75 = 2'b11
  } duty_e;

  typedef enum logic [1:0] {
    IDLE,
    MIX,
    DONE
  } state_e;

  // Number of high eighths of the period (wave is high while p3 < threshold).
  function automatic logic [2:0] duty_thr(input duty_e d);
    case (d)
      DUTY_12: duty_thr = 3'd1;
      DUTY_25: duty_thr = 3'd2;
      DUTY_50: duty_thr = 3'd4;
      default: duty_thr = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/ac97_sat20.sv
// Combinational signed saturation of a wide accumulator to a 20-bit sample.
module ac97_sat20
  import ac97_audio_pkg::*;
#(
  parameter int ACC_W = 23
) (
  input  logic signed [ACC_W-1:0]  din,
  output logic signed [SLOT_W-1:0] dout
);

  localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(SAMPLE_MAX);
  localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(SAMPLE_MIN);

  // Clamp to the signed 20-bit range, otherwise pass the low bits through.
  always_comb begin
    dout = din[SLOT_W-1:0];
    if (din > MAX_EXT)      dout = SAMPLE_MAX;
    else if (din < MIN_EXT) dout = SAMPLE_MIN;
  end

endmodule

// File: rtl/ac97_square_mixer.sv
// NUM_CH-voice square-wave generator with a time-multiplexed stereo mixer.
module ac97_square_mixer
  import ac97_audio_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PHASE_W   = 20,
  parameter int AMP_SHIFT = 12
) (
  input  logic                      ac97_bitclk,
  input  logic                      rst,
  input  logic                      ac97_strobe,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         ch_trigger,
  input  logic [NUM_CH*PHASE_W-1:0] ch_inc,
  input  logic [2*NUM_CH-1:0]       ch_duty,
  input  logic [4*NUM_CH-1:0]       ch_vol,
  input  logic [NUM_CH-1:0]         ch_pan_l,
  input  logic [NUM_CH-1:0]         ch_pan_r,
  output logic [SLOT_W-1:0]         ac97_out_slot3,
  output logic [SLOT_W-1:0]         ac97_out_slot4,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 21 + $clog2(NUM_CH);

  state_e state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [NUM_CH-1:0]  trig_pend;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [SLOT_W-1:0] mix_l, mix_r, sat_l, sat_r;
  logic strobe_q;

  logic               strobe_edge, process, last;
  logic [31:0]        sel;
  logic [PHASE_W-1:0] inc_sel, phase_new;
  logic [2:0]         p3;
  logic [3:0]         vol_sel;
  logic               en_sel, trig_sel, high;
  logic signed [ACC_W-1:0] amp, contrib, add_l, add_r;
  logic [NUM_CH-1:0]  clr_mask;

  // Shared per-voice datapath: one adder and one duty compare, steered by idx.
  always_comb begin
    strobe_edge = ac97_strobe & ~strobe_q;
    process     = (state == MIX) && !strobe_edge;
    last        = (idx == IDX_W'(NUM_CH - 1));
    sel         = 32'(idx);
    inc_sel     = ch_inc[sel*PHASE_W +: PHASE_W];
    en_sel      = ch_enable[sel];
    trig_sel    = trig_pend[sel] | ch_trigger[sel];
    phase_new   = (!en_sel || trig_sel) ? '0 : phase[idx] + inc_sel;
    p3          = phase_new[PHASE_W-1 -: 3];
    high        = p3 < duty_thr(duty_e'(ch_duty[sel*2 +: 2]));
    vol_sel     = ch_vol[sel*4 +: 4];
    amp         = $signed(ACC_W'(vol_sel) << AMP_SHIFT);
    contrib     = '0;
    if (en_sel) contrib = high ? amp : -amp;
    add_l       = ch_pan_l[sel] ? contrib : '0;
    add_r       = ch_pan_r[sel] ? contrib : '0;
    clr_mask    = process ? (NUM_CH'(1) << idx) : '0;
  end

  // Next-state logic; a strobe restarts the mix from any state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      MIX:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (strobe_edge) state_nx = MIX;
  end

  // State register and strobe edge history.
  always_ff @(posedge ac97_bitclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nx;
      strobe_q <= ac97_strobe;
    end
  end

  // Voice index, phase array and pending retriggers.
  always_ff @(posedge ac97_bitclk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      trig_pend <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) phase[i] <= '0;
    end else begin
      trig_pend <= (trig_pend | ch_trigger) & ~clr_mask;
      if (strobe_edge)        idx <= '0;
      else if (state == MIX)  idx <= idx + 1'b1;
      if (process) phase[idx] <= phase_new;
    end
  end

  // Accumulators, finished mix, output slots and status flags.
  always_ff @(posedge ac97_bitclk or posedge rst) begin
    if (rst) begin
      acc_l          <= '0;
      acc_r          <= '0;
      mix_l          <= '0;
      mix_r          <= '0;
      ac97_out_slot3 <= '0;
      ac97_out_slot4 <= '0;
      overrun        <= 1'b0;
    end else begin
      if (strobe_edge) begin
        acc_l          <= '0;
        acc_r          <= '0;
        ac97_out_slot3 <= mix_l;
        ac97_out_slot4 <= mix_r;
        if (state == MIX) overrun <= 1'b1;
      end else if (process) begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
      end
      if (state == DONE) begin
        mix_l <= sat_l;
        mix_r <= sat_r;
      end
    end
  end

  assign busy = (state == MIX);

  ac97_sat20 #(.ACC_W(ACC_W)) u_sat_l (.din(acc_l), .dout(sat_l));
  ac97_sat20 #(.ACC_W(ACC_W)) u_sat_r (.din(acc_r), .dout(sat_r));

endmodule

// File: tb/tb_ac97_square_mixer.sv
// Directed bench: tone sequence, duty, retrigger, overrun, saturation and reset.
module tb_ac97_square_mixer;

  logic clk = 1'b0;
  logic rst, strobe;
  logic [3:0]  ch_enable, ch_trigger, ch_pan_l, ch_pan_r;
  logic [79:0] ch_inc;
  logic [7:0]  ch_duty;
  logic [15:0] ch_vol;
  logic signed [19:0] slot3, slot4;
  logic busy, overrun;

  logic [3:0]  s_enable, s_trigger, s_pan_l, s_pan_r;
  logic [79:0] s_inc;
  logic [7:0]  s_duty;
  logic [15:0] s_vol;
  logic signed [19:0] s_slot3, s_slot4;
  logic s_busy, s_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int nb, nh;

  always #5 clk = ~clk;

  ac97_square_mixer #(.NUM_CH(4), .PHASE_W(20), .AMP_SHIFT(12)) dut (
    .ac97_bitclk(clk), .rst(rst), .ac97_strobe(strobe),
    .ch_enable(ch_enable), .ch_trigger(ch_trigger), .ch_inc(ch_inc),
    .ch_duty(ch_duty), .ch_vol(ch_vol), .ch_pan_l(ch_pan_l), .ch_pan_r(ch_pan_r),
    .ac97_out_slot3(slot3), .ac97_out_slot4(slot4), .busy(busy), .overrun(overrun)
  );

  ac97_square_mixer #(.NUM_CH(4), .PHASE_W(20), .AMP_SHIFT(14)) dut_sat (
    .ac97_bitclk(clk), .rst(rst), .ac97_strobe(strobe),
    .ch_enable(s_enable), .ch_trigger(s_trigger), .ch_inc(s_inc),
    .ch_duty(s_duty), .ch_vol(s_vol), .ch_pan_l(s_pan_l), .ch_pan_r(s_pan_r),
    .ac97_out_slot3(s_slot3), .ac97_out_slot4(s_slot4), .busy(s_busy), .overrun(s_overrun)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe pulse, then a full idle gap; returns the number of busy cycles.
  task automatic frame(output int busy_cycles);
    @(negedge clk) strobe = 1'b1;
    @(negedge clk) strobe = 1'b0;
    busy_cycles = 0;
    repeat (14) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  function automatic int tone_l(input int k);
    return ((k % 8) < 4) ? 61440 : -61440;
  endfunction

  initial begin
    rst = 1'b1; strobe = 1'b0;
    ch_enable = '0; ch_trigger = '0; ch_pan_l = '0; ch_pan_r = '0;
    ch_inc = '0; ch_duty = '0; ch_vol = '0;
    s_enable = 4'hF; s_trigger = '0; s_pan_l = 4'hF; s_pan_r = 4'hF;
    s_inc = '0; s_duty = 8'hFF; s_vol = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_slot3", slot3, 0);
    check_eq("reset_slot4", slot4, 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_overrun", 32'(overrun), 0);

    // Saturation: four voices at 15<<14 all high, then all low.
    frame(nb);
    frame(nb);
    check_eq("sat_high_l", s_slot3, 524287);
    check_eq("sat_high_r", s_slot4, 524287);
    check_eq("idle_voices_l", slot3, 0);
    s_inc = {4{20'h80000}}; s_duty = 8'h00;
    frame(nb);
    frame(nb);
    check_eq("sat_low_l", s_slot3, -524288);
    check_eq("sat_low_r", s_slot4, -524288);

    // Single voice, 50% duty, left only.
    ch_enable = 4'b0001; ch_pan_l = 4'b0001; ch_inc[19:0] = 20'h20000;
    ch_duty[1:0] = 2'b10; ch_vol[3:0] = 4'd15;
    frame(nb);
    check_eq("busy_cycles_prime", nb, 4);
    for (int k = 1; k <= 9; k++) begin
      frame(nb);
      check_eq($sformatf("tone_l_%0d", k), slot3, tone_l(k));
      check_eq($sformatf("tone_r_%0d", k), slot4, 0);
      if (k <= 2) check_eq($sformatf("busy_cycles_%0d", k), nb, 4);
    end

    // Duty 12.5% and 75%: high frames per eight-frame period.
    ch_duty[1:0] = 2'b00;
    frame(nb);
    nh = 0;
    for (int k = 0; k < 8; k++) begin
      frame(nb);
      if (slot3 > 0) nh++;
    end
    check_eq("duty00_high_frames", nh, 1);
    ch_duty[1:0] = 2'b11;
    frame(nb);
    nh = 0;
    for (int k = 0; k < 8; k++) begin
      frame(nb);
      if (slot3 > 0) nh++;
    end
    check_eq("duty11_high_frames", nh, 6);

    // Retrigger voice 1 (right only, vol 2) from an arbitrary phase.
    ch_enable[1] = 1'b1; ch_pan_r[1] = 1'b1; ch_inc[39:20] = 20'd196608;
    ch_duty[3:2] = 2'b10; ch_vol[7:4] = 4'd2;
    repeat (3) frame(nb);
    check_eq("v1_phase_3frames", 32'(dut.phase[1]), 589824);
    @(negedge clk) ch_trigger = 4'b0010;
    @(negedge clk) ch_trigger = 4'b0000;
    frame(nb);
    check_eq("v1_phase_retrig", 32'(dut.phase[1]), 0);
    check_eq("v1_low_before", slot4, -8192);
    frame(nb);
    check_eq("v1_high_after", slot4, 8192);

    // Disable voice 1.
    ch_enable[1] = 1'b0;
    frame(nb);
    check_eq("v1_phase_disabled", 32'(dut.phase[1]), 0);
    frame(nb);
    check_eq("v1_disabled_r", slot4, 0);

    // Overrun: second strobe two cycles after the first.
    ch_inc[19:0] = '0; ch_duty[1:0] = 2'b10;
    @(negedge clk) ch_trigger = 4'b0001;
    @(negedge clk) ch_trigger = 4'b0000;
    frame(nb);
    frame(nb);
    check_eq("pre_overrun_flag", 32'(overrun), 0);
    ch_vol[3:0] = 4'd5;
    @(negedge clk) strobe = 1'b1;
    @(negedge clk) strobe = 1'b0;
    check_eq("strobe_b_l", slot3, 61440);
    @(negedge clk) strobe = 1'b1;
    @(negedge clk) strobe = 1'b0;
    check_eq("overrun_flag", 32'(overrun), 1);
    check_eq("overrun_slot_l", slot3, 61440);
    nb = 0;
    repeat (14) begin
      if (busy) nb++;
      @(negedge clk);
    end
    check_eq("overrun_restart_busy", nb, 4);
    frame(nb);
    check_eq("after_overrun_l", slot3, 20480);
    check_eq("overrun_sticky", 32'(overrun), 1);

    // Reset asserted while voice 2 is being mixed.
    ch_inc[19:0] = 20'h20000;
    @(negedge clk) strobe = 1'b1;
    @(negedge clk) strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midmix_slot3", slot3, 0);
    check_eq("midmix_slot4", slot4, 0);
    check_eq("midmix_busy", 32'(busy), 0);
    check_eq("midmix_overrun", 32'(overrun), 0);
    check_eq("midmix_phase0", 32'(dut.phase[0]), 0);
    check_eq("midmix_phase1", 32'(dut.phase[1]), 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
